bus_source_sequencer: RTL and testbench

Control-step sequencer that sits directly upstream of the 32-to-5 bus encoder. It walks a fixed fetch/execute microsequence (T0..T6) and, each step, drives a registered one-hot vector of 24 bus-source enables (R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout) plus the matching binary select. It also drives the destination-latch strobes and the memory-read handshake for the datapath.

---
 rtl/bus_source_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_bus_source_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_source_sequencer.sv
// Control-step sequencer feeding the 32-to-5 bus encoder.
// Walks the T0..T6 fetch/execute microsequence and drives one-hot bus-source
// enables, the matching binary select, datapath latch strobes and the memory
// read handshake. Every output except mdr_in comes straight from a flop.
// mdr_in must be high in the same T1 cycle that mem_ready arrives, so it is
// the registered mem_read strobe gated by mem_ready.
module bus_source_sequencer #(
  parameter int NUM_SRC     = 24,
  parameter int SEL_W       = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic [2:0]         op_class,
  input  logic [3:0]         ra,
  input  logic [3:0]         rb,
  input  logic [3:0]         rc,
  input  logic               mem_ready,
  output logic [NUM_SRC-1:0] src_onehot,
  output logic [SEL_W-1:0]   src_sel,
  output logic               mar_in,
  output logic               inc_pc,
  output logic               pc_in,
  output logic               mem_read,
  output logic               mdr_in,
  output logic               ir_in,
  output logic               y_in,
  output logic               z_in,
  output logic               hi_in,
  output logic               lo_in,
  output logic               rf_wr,
  output logic [3:0]         rf_wr_addr,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  // Bus source indices above the register file.
  localparam logic [SEL_W-1:0] SRC_HI    = 5'd16;
  localparam logic [SEL_W-1:0] SRC_LO    = 5'd17;
  localparam logic [SEL_W-1:0] SRC_ZHIGH = 5'd18;
  localparam logic [SEL_W-1:0] SRC_ZLOW  = 5'd19;
  localparam logic [SEL_W-1:0] SRC_PC    = 5'd20;
  localparam logic [SEL_W-1:0] SRC_MDR   = 5'd21;
  localparam logic [SEL_W-1:0] SRC_C     = 5'd23;

  typedef enum logic [2:0] {
    IDLE = 3'd0, T0 = 3'd1, T1 = 3'd2, T2 = 3'd3,
    T3 = 3'd4, T4 = 3'd5, T5 = 3'd6, T6 = 3'd7
  } state_t;

  state_t           state;
  logic [2:0]       op_r;
  logic [3:0]       ra_r;
  logic [3:0]       rb_r;
  logic [3:0]       rc_r;
  logic [CNT_W-1:0] tcnt_r;

  // Decode a source index into its one-hot enable vector.
  function automatic logic [NUM_SRC-1:0] onehot_f(input logic [SEL_W-1:0] idx);
    return {{(NUM_SRC-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Latch the MDR in the very cycle read data is presented during T1.
  assign mdr_in = mem_read & mem_ready;

  // Sequencer FSM: next step plus the registered outputs for that step.
  always_ff @(posedge clk) begin
    if (!clear) begin
      state      <= IDLE;
      op_r       <= 3'd0;
      ra_r       <= 4'd0;
      rb_r       <= 4'd0;
      rc_r       <= 4'd0;
      tcnt_r     <= '0;
      src_onehot <= '0;
      src_sel    <= '0;
      mar_in     <= 1'b0;
      inc_pc     <= 1'b0;
      pc_in      <= 1'b0;
      mem_read   <= 1'b0;
      ir_in      <= 1'b0;
      y_in       <= 1'b0;
      z_in       <= 1'b0;
      hi_in      <= 1'b0;
      lo_in      <= 1'b0;
      rf_wr      <= 1'b0;
      rf_wr_addr <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      src_onehot <= '0;
      src_sel    <= '0;
      mar_in     <= 1'b0;
      inc_pc     <= 1'b0;
      pc_in      <= 1'b0;
      mem_read   <= 1'b0;
      ir_in      <= 1'b0;
      y_in       <= 1'b0;
      z_in       <= 1'b0;
      hi_in      <= 1'b0;
      lo_in      <= 1'b0;
      rf_wr      <= 1'b0;
      rf_wr_addr <= 4'd0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          tcnt_r <= '0;
          if (start) begin
            op_r       <= op_class;
            ra_r       <= ra;
            rb_r       <= rb;
            rc_r       <= rc;
            state      <= T0;
            busy       <= 1'b1;
            src_onehot <= onehot_f(SRC_PC);
            src_sel    <= SRC_PC;
            mar_in     <= 1'b1;
            inc_pc     <= 1'b1;
            z_in       <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        T0: begin
          state      <= T1;
          tcnt_r     <= '0;
          src_onehot <= onehot_f(SRC_ZLOW);
          src_sel    <= SRC_ZLOW;
          pc_in      <= 1'b1;
          mem_read   <= 1'b1;
        end
        T1: begin
          if (mem_ready) begin
            state      <= T2;
            tcnt_r     <= '0;
            src_onehot <= onehot_f(SRC_MDR);
            src_sel    <= SRC_MDR;
            ir_in      <= 1'b1;
          end else if (tcnt_r >= CNT_W'(MEM_TIMEOUT - 1)) begin
            // Memory never answered: abort without a done pulse.
            state  <= IDLE;
            tcnt_r <= '0;
            busy   <= 1'b0;
            err    <= 1'b1;
          end else begin
            tcnt_r     <= tcnt_r + CNT_W'(1);
            src_onehot <= onehot_f(SRC_ZLOW);
            src_sel    <= SRC_ZLOW;
            pc_in      <= 1'b1;
            mem_read   <= 1'b1;
          end
        end
        T2: begin
          case (op_r)
            3'd0, 3'd1, 3'd4: begin
              state      <= T3;
              src_onehot <= onehot_f({1'b0, rb_r});
              src_sel    <= {1'b0, rb_r};
              y_in       <= 1'b1;
            end
            3'd2, 3'd3: begin
              state      <= T3;
              src_onehot <= onehot_f((op_r == 3'd2) ? SRC_HI : SRC_LO);
              src_sel    <= (op_r == 3'd2) ? SRC_HI : SRC_LO;
              rf_wr      <= 1'b1;
              rf_wr_addr <= ra_r;
              done       <= 1'b1;
            end
            default: begin
              state <= IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          endcase
        end
        T3: begin
          if ((op_r == 3'd2) || (op_r == 3'd3)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (op_r == 3'd4) begin
            state      <= T4;
            src_onehot <= onehot_f(SRC_C);
            src_sel    <= SRC_C;
            z_in       <= 1'b1;
          end else begin
            state      <= T4;
            src_onehot <= onehot_f({1'b0, rc_r});
            src_sel    <= {1'b0, rc_r};
            z_in       <= 1'b1;
          end
        end
        T4: begin
          state      <= T5;
          src_onehot <= onehot_f(SRC_ZLOW);
          src_sel    <= SRC_ZLOW;
          if (op_r == 3'd1) begin
            lo_in <= 1'b1;
          end else begin
            rf_wr      <= 1'b1;
            rf_wr_addr <= ra_r;
            done       <= 1'b1;
          end
        end
        T5: begin
          if (op_r == 3'd1) begin
            state      <= T6;
            src_onehot <= onehot_f(SRC_ZHIGH);
            src_sel    <= SRC_ZHIGH;
            hi_in      <= 1'b1;
            done       <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        T6: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_source_sequencer.sv
// Directed bench for bus_source_sequencer with hand-computed expectations.
module tb_bus_source_sequencer;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [2:0]  op_class;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic        mem_ready;
  logic [23:0] src_onehot;
  logic [4:0]  src_sel;
  logic        mar_in, inc_pc, pc_in, mem_read, mdr_in, ir_in;
  logic        y_in, z_in, hi_in, lo_in, rf_wr;
  logic [3:0]  rf_wr_addr;
  logic        busy, done, err;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;

  bus_source_sequencer dut (
    .clk(clk), .clear(clear), .start(start), .op_class(op_class),
    .ra(ra), .rb(rb), .rc(rc), .mem_ready(mem_ready),
    .src_onehot(src_onehot), .src_sel(src_sel),
    .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in), .mem_read(mem_read),
    .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
    .hi_in(hi_in), .lo_in(lo_in), .rf_wr(rf_wr), .rf_wr_addr(rf_wr_addr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Count done pulses so an aborted sequence can be shown to never finish.
  always @(posedge clk) if (done === 1'b1) done_cnt++;

  // Bus-source invariant: zero or one-hot, with select matching the set bit.
  always @(negedge clk) begin
    logic ok;
    ok = ((src_onehot == 24'd0) && (src_sel == 5'd0)) ||
         ((src_sel < 5'd24) && (src_onehot == (24'd1 << src_sel)));
    chk("onehot_inv", {31'd0, ok}, 32'd1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] c, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] d);
    op_class = c; ra = a; rb = b; rc = d; start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble inputs: the captured copies must be used from here on.
    op_class = 3'd7; ra = 4'd15; rb = 4'd14; rc = 4'd13;
  endtask

  initial begin
    int base;
    clear = 1'b0; start = 1'b0; op_class = 3'd0;
    ra = 4'd0; rb = 4'd0; rc = 4'd0; mem_ready = 1'b0;
    tick(); tick();
    clear = 1'b1;
    chk("rst_onehot", {8'd0, src_onehot}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    // Class 0: rb=3, rc=7, ra=5, memory ready at once.
    mem_ready = 1'b1;
    start_op(3'd0, 4'd5, 4'd3, 4'd7);
    chk("c0_t0_sel", {27'd0, src_sel}, 32'd20);
    chk("c0_t0_strb", {29'd0, mar_in, inc_pc, z_in}, 32'd7);
    chk("c0_t0_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("c0_t1_sel", {27'd0, src_sel}, 32'd19);
    chk("c0_t1_strb", {29'd0, pc_in, mem_read, mdr_in}, 32'd7);
    tick();
    chk("c0_t2_sel", {27'd0, src_sel}, 32'd21);
    chk("c0_t2_ir", {31'd0, ir_in}, 32'd1);
    tick();
    chk("c0_t3_sel", {27'd0, src_sel}, 32'd3);
    chk("c0_t3_y", {31'd0, y_in}, 32'd1);
    tick();
    chk("c0_t4_sel", {27'd0, src_sel}, 32'd7);
    chk("c0_t4_z", {31'd0, z_in}, 32'd1);
    tick();
    chk("c0_t5_sel", {27'd0, src_sel}, 32'd19);
    chk("c0_t5_wr", {31'd0, rf_wr}, 32'd1);
    chk("c0_t5_addr", {28'd0, rf_wr_addr}, 32'd5);
    chk("c0_t5_done", {30'd0, done, busy}, 32'd3);
    tick();
    chk("c0_idle", {25'd0, done, busy, src_sel}, 32'd0);

    // Class 1: rb=2, rc=4.
    start_op(3'd1, 4'd8, 4'd2, 4'd4);
    tick(); tick(); tick();
    chk("c1_t3_sel", {27'd0, src_sel}, 32'd2);
    tick();
    chk("c1_t4_sel", {27'd0, src_sel}, 32'd4);
    tick();
    chk("c1_t5_sel", {27'd0, src_sel}, 32'd19);
    chk("c1_t5_lo", {29'd0, lo_in, rf_wr, done}, 32'd4);
    tick();
    chk("c1_t6_sel", {27'd0, src_sel}, 32'd18);
    chk("c1_t6_hi", {29'd0, hi_in, rf_wr, done}, 32'd5);
    tick();
    chk("c1_idle_busy", {31'd0, busy}, 32'd0);

    // Class 4: rb=1, ra=9, mem_ready three cycles late.
    mem_ready = 1'b0;
    start_op(3'd4, 4'd9, 4'd1, 4'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("c4_wait_sel", {27'd0, src_sel}, 32'd19);
      chk("c4_wait_rd", {30'd0, mem_read, mdr_in}, 32'd2);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("c4_t1_last", {30'd0, mem_read, mdr_in}, 32'd3);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("c4_t2_sel", {27'd0, src_sel}, 32'd21);
    chk("c4_t2_mdr", {31'd0, mdr_in}, 32'd0);
    tick();
    chk("c4_t3_sel", {27'd0, src_sel}, 32'd1);
    tick();
    chk("c4_t4_sel", {27'd0, src_sel}, 32'd23);
    chk("c4_t4_oh", {8'd0, src_onehot}, 32'h0080_0000);
    chk("c4_t4_z", {31'd0, z_in}, 32'd1);
    tick();
    chk("c4_t5_addr", {27'd0, rf_wr, rf_wr_addr}, 32'd25);
    tick();

    // Class 2 with start held: done-cycle start ignored, then class 3.
    mem_ready = 1'b1;
    op_class = 3'd2; ra = 4'd12; start = 1'b1;
    tick(); tick(); tick(); tick();
    chk("c2_t3_sel", {27'd0, src_sel}, 32'd16);
    chk("c2_t3_wr", {26'd0, done, rf_wr, rf_wr_addr}, 32'd60);
    op_class = 3'd3; ra = 4'd6;
    tick();
    chk("c2_after_busy", {31'd0, busy}, 32'd0);
    chk("c2_after_sel", {27'd0, src_sel}, 32'd0);
    tick();
    start = 1'b0;
    chk("c3_t0_sel", {27'd0, src_sel}, 32'd20);
    tick(); tick(); tick();
    chk("c3_t3_sel", {27'd0, src_sel}, 32'd17);
    chk("c3_t3_addr", {27'd0, rf_wr, rf_wr_addr}, 32'd22);
    tick();

    // Reset in the middle of T4 of a class 0 instruction.
    start_op(3'd0, 4'd5, 4'd3, 4'd7);
    tick(); tick(); tick(); tick();
    chk("mid_t4_sel", {27'd0, src_sel}, 32'd7);
    clear = 1'b0;
    tick();
    clear = 1'b1;
    chk("mid_rst_oh", {8'd0, src_onehot}, 32'd0);
    chk("mid_rst_flags", {28'd0, busy, err, done, z_in}, 32'd0);
    tick();
    chk("mid_rst_idle", {27'd0, src_sel}, 32'd0);

    // Illegal class 6, start held throughout.
    op_class = 3'd6; start = 1'b1;
    tick(); tick(); tick();
    chk("ill_t2_sel", {27'd0, src_sel}, 32'd21);
    chk("ill_t2_err", {31'd0, err}, 32'd0);
    tick();
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_idle", {26'd0, busy, src_sel}, 32'd0);
    tick();
    chk("ill_restart", {26'd0, busy, src_sel}, 32'd52);
    start = 1'b0;
    tick(); tick(); tick();
    chk("ill_sticky", {31'd0, err}, 32'd1);

    // Memory timeout with mem_ready held low.
    clear = 1'b0; tick(); clear = 1'b1;
    mem_ready = 1'b0;
    base = done_cnt;
    start_op(3'd0, 4'd1, 4'd2, 4'd3);
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("to_wait_rd", {30'd0, mem_read, err}, 32'd2);
      tick();
    end
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_idle", {29'd0, busy, mem_read, done}, 32'd0);
    tick(); tick(); tick();
    chk("to_sticky", {31'd0, err}, 32'd1);
    chk("to_no_done", done_cnt - base, 32'd0);
    clear = 1'b0; tick(); clear = 1'b1;
    chk("to_rst_err", {31'd0, err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
